jtgng_zxdos_romload_arb: RTL and testbench
==========================================

// Module: jtgng_zxdos_romload_arb
// PURPOSE
//  Sits between the SD/SPI ROM loader byte stream (ioctl_*) and the single SDRAM port in zxdos builds.
//  Packs loader bytes into 16-bit words and buffers them in a 2-entry FIFO.
//  Arbitrates the SDRAM port between download writes and game ROM reads.
//  Holds the game in reset until the download is complete, flushed, and a settle time has elapsed.
// PARAMETERS
//  AW        22  byte address width of ioctl_addr; SDRAM word address is AW-1 bits
//  POST_RST  16  clk_rom cycles that game_rst_n stays low after the flush completes (>=1)
// PORTS
//  clk_rom      in   1      single clock; every flop is on its rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  downloading  in   1      level; high while the loader is streaming the ROM
//  ioctl_addr   in   AW     byte address of ioctl_data
//  ioctl_data   in   8      loader byte
//  ioctl_wr     in   1      1-cycle strobe; ioctl_addr and ioctl_data are valid on this cycle
//  game_req     in   1      level; game read request; held until game_rdy
//  game_addr    in   AW-1   word address; stable while game_req is high
//  game_dout    out  16     read data; valid only when game_rdy=1
//  game_rdy     out  1      1-cycle pulse: read complete
//  sdram_req    out  1      request; held high until sdram_ack
//  sdram_we     out  1      1 = write, 0 = read
//  sdram_addr   out  AW-1   word address
//  sdram_din    out  16     write data
//  sdram_mask   out  2      byte enables; bit0 = low byte
//  sdram_ack    in   1      1-cycle pulse: request accepted
//  sdram_rdy    in   1      1-cycle pulse: read data valid on sdram_dout
//  sdram_dout   in   16     read data from SDRAM
//  game_rst_n   out  1      active-low reset to the game core
//  dwn_done     out  1      1-cycle pulse when game_rst_n rises
//  overflow     out  1      sticky; set when a packed word is dropped because the FIFO is full
// BEHAVIOUR
//  Reset values: all outputs 0, except game_rst_n = 0. FIFO empty. FSM in IDLE. Packer empty.
//  Packer (word address = ioctl_addr[AW-1:1]):
//   - Even-address byte goes to the low byte; odd-address byte goes to the high byte.
//   - A word is committed when the odd byte arrives.
//   - A word is also committed early when the next ioctl_wr has a different word address, or when downloading falls.
//     The early commit is a partial word; sdram_mask holds only the bytes actually written.
//   - A byte that is not adjacent to the pending byte (e.g. odd-then-even) forces an early commit of the pending byte,
//     then the new byte starts a new word.
//  FIFO: 2 entries of {addr, data, mask}.
//   - A commit into a full FIFO drops the word and sets overflow. overflow clears only on reset.
//   - A push and a pop in the same cycle are both legal when the FIFO is full.
//  FSM states: IDLE, WR, RD, RDW.
//   - IDLE -> WR when the FIFO is not empty. FIFO writes always have priority over game reads.
//   - IDLE -> RD when the FIFO is empty, game_req=1 and game_rst_n=1. game_addr is latched on entry.
//   - WR: sdram_req=1, sdram_we=1, head entry driven onto the SDRAM bus. On sdram_ack: pop the FIFO, go to IDLE.
//   - RD: sdram_req=1, sdram_we=0. On sdram_ack go to RDW.
//   - RDW: on sdram_rdy, game_dout <= sdram_dout, pulse game_rdy, go to IDLE.
//     A new game read cannot start earlier than 1 cycle after game_rdy.
//   - sdram_addr, sdram_din, sdram_mask and sdram_we stay stable while sdram_req is high.
//   - sdram_req drops in the cycle after sdram_ack.
//  Reset sequencing:
//   - game_rst_n is forced low while downloading=1.
//   - After downloading falls, the block waits for: partial-word flush, FIFO empty, FSM in IDLE.
//   - It then counts POST_RST cycles, raises game_rst_n, and pulses dwn_done in that same cycle.
//   - If downloading rises again at any point, the counter clears and game_rst_n goes low the next cycle.
//   - A game read in RD/RDW when downloading rises still completes normally; new reads are blocked.
//  Simultaneous events: ioctl_wr is accepted in the same cycle as the falling edge of downloading.
//   That byte is packed first, then flushed.
//  rst_n asserted mid-transfer: sdram_req drops immediately (asynchronously). Buffered data is lost.
// CONFIGURATION
//  JTGNG_ROMLOAD_CHKSUM_EN defined:
//   - Adds output chksum [15:0]: 16-bit wrap-around sum of every byte accepted on ioctl_wr.
//   - Dropped words are still included in the sum.
//   - Clears on reset and on the rising edge of downloading; holds its value after the download ends.
//  Not defined: the chksum port is absent and no adder is built.
// TESTING
//  1. Bytes 0x11@0, 0x22@1, 0x33@2, 0x44@3, then downloading falls
//     -> writes {0x2211, mask 11}@0 and {0x4433, mask 11}@1.
//     -> After POST_RST cycles, game_rst_n=1 and dwn_done pulses once.
//  2. Single byte 0xAB@5, then downloading falls -> one write 0xAB00 @2, mask 10.
//  3. sdram_ack withheld for 20 cycles while 8 bytes stream 1 per cycle
//     -> overflow=1; exactly 2 words are written after ack resumes.
//  4. Idle after download; game_req with game_addr=0x0100; sdram_rdy returns 0xBEEF
//     -> game_rdy pulses for 1 cycle with game_dout=0xBEEF.
//  5. downloading rises mid-countdown -> game_rst_n stays 0, no dwn_done.
//     Restart the download and let it complete -> single dwn_done.
//  6. CHKSUM_EN: bytes 0xFF,0xFF,0x02 -> chksum=0x0200.
//     Then downloading rises -> chksum=0x0000.

Source files
------------

// File: rtl/jtgng_zxdos_romload_arb.sv
// ROM loader to SDRAM bridge for zxdos builds: byte packer, 2-entry write FIFO,
// SDRAM port arbiter and game reset sequencer. Optional JTGNG_ROMLOAD_CHKSUM_EN adds a byte checksum.
module jtgng_zxdos_romload_arb #(
  parameter int AW       = 22,
  parameter int POST_RST = 16
) (
  input  logic          clk_rom,
  input  logic          rst_n,
  input  logic          downloading,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [7:0]    ioctl_data,
  input  logic          ioctl_wr,
  input  logic          game_req,
  input  logic [AW-2:0] game_addr,
  output logic [15:0]   game_dout,
  output logic          game_rdy,
  output logic          sdram_req,
  output logic          sdram_we,
  output logic [AW-2:0] sdram_addr,
  output logic [15:0]   sdram_din,
  output logic [1:0]    sdram_mask,
  input  logic          sdram_ack,
  input  logic          sdram_rdy,
  input  logic [15:0]   sdram_dout,
  output logic          game_rst_n,
  output logic          dwn_done,
  output logic          overflow,
  output logic [1:0]    state_dbg
`ifdef JTGNG_ROMLOAD_CHKSUM_EN
  ,output logic [15:0]  chksum
`endif
);

  localparam int WA = AW - 1;
  localparam int EW = WA + 18;
  localparam int CW = $clog2(POST_RST + 1);
  localparam logic [CW-1:0] LAST = CW'(POST_RST - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WR   = 2'd1;
  localparam logic [1:0] RD   = 2'd2;
  localparam logic [1:0] RDW  = 2'd3;

  // SDRAM handshake: sdram_req holds with stable we/addr/din/mask until the
  // cycle sdram_ack is sampled high; the request drops on the following cycle.
  // A read then completes on the single-cycle sdram_rdy pulse.

  logic [1:0]    state;
  logic [WA-1:0] rd_addr;

  // ---------------- packer ----------------
  logic          pend_valid;
  logic [WA-1:0] pend_addr;
  logic [15:0]   pend_data;
  logic [1:0]    pend_mask;
  logic [WA-1:0] io_wa;
  logic          io_odd;
  logic          push, load, clear;
  logic [WA-1:0] push_addr;
  logic [15:0]   push_data;
  logic [1:0]    push_mask;

  assign io_wa  = ioctl_addr[AW-1:1];
  assign io_odd = ioctl_addr[0];

  // At most one word leaves the packer per cycle; a lone odd byte that arrives
  // while another byte is pending waits one cycle in the pending register.
  always_comb begin
    push      = 1'b0;
    load      = 1'b0;
    clear     = 1'b0;
    push_addr = pend_addr;
    push_data = pend_data;
    push_mask = pend_mask;
    if (ioctl_wr) begin
      if (pend_valid && pend_mask == 2'b01 && io_odd && io_wa == pend_addr) begin
        push      = 1'b1;
        push_data = {ioctl_data, pend_data[7:0]};
        push_mask = 2'b11;
        clear     = 1'b1;
      end else if (pend_valid) begin
        push = 1'b1;
        load = 1'b1;
      end else if (io_odd) begin
        push      = 1'b1;
        push_addr = io_wa;
        push_data = {ioctl_data, 8'h00};
        push_mask = 2'b10;
      end else begin
        load = 1'b1;
      end
    end else if (pend_valid && (pend_mask[1] || !downloading)) begin
      push  = 1'b1;
      clear = 1'b1;
    end
  end

  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
      pend_mask  <= '0;
    end else if (load) begin
      pend_valid <= 1'b1;
      pend_addr  <= io_wa;
      pend_data  <= io_odd ? {ioctl_data, 8'h00} : {8'h00, ioctl_data};
      pend_mask  <= io_odd ? 2'b10 : 2'b01;
    end else if (clear) begin
      pend_valid <= 1'b0;
    end
  end

  // ---------------- FIFO ----------------
  logic [EW-1:0] mem [2];
  logic          wp, rp;
  logic [1:0]    fifo_cnt;
  logic          fifo_full, fifo_empty, pop, push_ok;
  logic [WA-1:0] h_addr;
  logic [15:0]   h_data;
  logic [1:0]    h_mask;

  assign fifo_full  = fifo_cnt == 2'd2;
  assign fifo_empty = fifo_cnt == 2'd0;
  assign pop        = state == WR && sdram_ack;
  assign push_ok    = push && (!fifo_full || pop);
  assign {h_addr, h_data, h_mask} = mem[rp];

  always_ff @(posedge clk_rom) begin
    if (push_ok) mem[wp] <= {push_addr, push_data, push_mask};
  end

  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      wp       <= 1'b0;
      rp       <= 1'b0;
      fifo_cnt <= 2'd0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wp <= ~wp;
      if (pop)     rp <= ~rp;
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

  // ---------------- arbiter FSM ----------------
  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_addr   <= '0;
      game_dout <= '0;
      game_rdy  <= 1'b0;
    end else begin
      game_rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state <= WR;
          end else if (game_req && game_rst_n && !downloading && !game_rdy) begin
            state   <= RD;
            rd_addr <= game_addr;
          end
        end
        WR:  if (sdram_ack) state <= IDLE;
        RD:  if (sdram_ack) state <= RDW;
        RDW: begin
          if (sdram_rdy) begin
            game_dout <= sdram_dout;
            game_rdy  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign state_dbg = state;
  assign sdram_req = state == WR || state == RD;
  assign sdram_we  = state == WR;

  always_comb begin
    sdram_addr = '0;
    sdram_din  = '0;
    sdram_mask = '0;
    case (state)
      WR: begin
        sdram_addr = h_addr;
        sdram_din  = h_data;
        sdram_mask = h_mask;
      end
      RD: begin
        sdram_addr = rd_addr;
        sdram_mask = 2'b11;
      end
      RDW:     sdram_addr = rd_addr;
      default: sdram_addr = '0;
    endcase
  end

  // ---------------- game reset sequencer ----------------
  logic          armed, idle_ok;
  logic [CW-1:0] rst_cnt;

  assign idle_ok = !pend_valid && fifo_empty && state == IDLE;

  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      game_rst_n <= 1'b0;
      dwn_done   <= 1'b0;
      rst_cnt    <= '0;
      armed      <= 1'b0;
    end else begin
      dwn_done <= 1'b0;
      if (downloading) begin
        game_rst_n <= 1'b0;
        rst_cnt    <= '0;
        armed      <= 1'b1;
      end else if (armed && !game_rst_n) begin
        if (!idle_ok) begin
          rst_cnt <= '0;
        end else if (rst_cnt == LAST) begin
          game_rst_n <= 1'b1;
          dwn_done   <= 1'b1;
          rst_cnt    <= '0;
        end else begin
          rst_cnt <= rst_cnt + 1'b1;
        end
      end
    end
  end

`ifdef JTGNG_ROMLOAD_CHKSUM_EN
  logic dl_q;
  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      dl_q   <= 1'b0;
      chksum <= '0;
    end else begin
      dl_q <= downloading;
      if (downloading && !dl_q)
        chksum <= ioctl_wr ? {8'h00, ioctl_data} : 16'h0000;
      else if (ioctl_wr)
        chksum <= chksum + {8'h00, ioctl_data};
    end
  end
`endif

endmodule

// File: tb/tb_jtgng_zxdos_romload_arb.sv
// Directed bench for jtgng_zxdos_romload_arb: SDRAM responder plus a linear sequence of checked steps.
module tb_jtgng_zxdos_romload_arb;

  localparam int AW       = 22;
  localparam int POST_RST = 4;
  localparam int EW       = AW - 1 + 18;

  logic          clk, rst_n, downloading;
  logic [AW-1:0] ioctl_addr;
  logic [7:0]    ioctl_data;
  logic          ioctl_wr;
  logic          game_req;
  logic [AW-2:0] game_addr;
  logic [15:0]   game_dout;
  logic          game_rdy;
  logic          sdram_req, sdram_we;
  logic [AW-2:0] sdram_addr;
  logic [15:0]   sdram_din;
  logic [1:0]    sdram_mask;
  logic          sdram_ack, sdram_rdy;
  logic [15:0]   sdram_dout;
  logic          game_rst_n, dwn_done, overflow;
  logic [1:0]    state_dbg;
`ifdef JTGNG_ROMLOAD_CHKSUM_EN
  logic [15:0]   chksum;
`endif

  jtgng_zxdos_romload_arb #(.AW(AW), .POST_RST(POST_RST)) dut (
    .clk_rom(clk), .rst_n(rst_n), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .game_req(game_req), .game_addr(game_addr), .game_dout(game_dout), .game_rdy(game_rdy),
    .sdram_req(sdram_req), .sdram_we(sdram_we), .sdram_addr(sdram_addr),
    .sdram_din(sdram_din), .sdram_mask(sdram_mask), .sdram_ack(sdram_ack),
    .sdram_rdy(sdram_rdy), .sdram_dout(sdram_dout),
    .game_rst_n(game_rst_n), .dwn_done(dwn_done), .overflow(overflow),
    .state_dbg(state_dbg)
`ifdef JTGNG_ROMLOAD_CHKSUM_EN
    ,.chksum(chksum)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] wr_log[$];
  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] ent(input logic [AW-2:0] a, input logic [15:0] d,
                                        input logic [1:0] m);
    return {a, d, m};
  endfunction

  task automatic check_writes(input string tag);
    chk({tag, "_count"}, 64'(wr_log.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && wr_log.size() > 0)
      chk(tag, 64'(wr_log.pop_front()), 64'(exp_q.pop_front()));
    exp_q.delete();
    wr_log.delete();
  endtask

  // ---------------- SDRAM responder ----------------
  logic          ack_en;
  logic [15:0]   rd_data;
  logic [AW-2:0] rd_addr_seen;
  int rd_wait = 0;
  int ack_cyc = 0;
  int done_cnt = 0;
  int rdy_cnt = 0;

  always @(negedge clk) begin
    sdram_ack = 1'b0;
    sdram_rdy = 1'b0;
    if (game_rdy) rdy_cnt++;
    if (dwn_done) done_cnt++;
    if (!rst_n) begin
      rd_wait = 0;
    end else if (rd_wait != 0) begin
      rd_wait--;
      if (rd_wait == 0) begin
        sdram_rdy  = 1'b1;
        sdram_dout = rd_data;
      end
    end else if (sdram_req && ack_en) begin
      sdram_ack = 1'b1;
      if (sdram_we) begin
        wr_log.push_back({sdram_addr, sdram_din, sdram_mask});
        ack_cyc = cyc;
      end else begin
        rd_addr_seen = sdram_addr;
        rd_wait = 2;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [AW-1:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    @(negedge clk);
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_rise(input string tag, output int rise_c);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (game_rst_n) break;
    end
    chk(tag, 64'(game_rst_n), 64'd1);
    rise_c = cyc;
  endtask

  // ---------------- directed sequence ----------------
  int rise_c;
  int done_before;

  initial begin
    rst_n = 1'b0; downloading = 1'b0; ioctl_addr = '0; ioctl_data = '0; ioctl_wr = 1'b0;
    game_req = 1'b0; game_addr = '0; sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_dout = '0;
    ack_en = 1'b1; rd_data = 16'h0000; rd_addr_seen = '0;

    tick(2);
    chk("rst_sdram_req", 64'(sdram_req), 64'd0);
    chk("rst_game_rst_n", 64'(game_rst_n), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_outputs", 64'({game_rdy, dwn_done, sdram_we, sdram_mask, sdram_addr, game_dout}), 64'd0);
    rst_n = 1'b1;
    tick(3);
    chk("no_dl_no_release", 64'(game_rst_n), 64'd0);

    // T1: four bytes, two full words
    downloading = 1'b1;
    tick(2);
    send_byte(22'd0, 8'h11);
    send_byte(22'd1, 8'h22);
    send_byte(22'd2, 8'h33);
    send_byte(22'd3, 8'h44);
    downloading = 1'b0;
    wait_rise("t1_rise", rise_c);
    chk("t1_done_with_rise", 64'(dwn_done), 64'd1);
    chk("t1_latency", 64'(rise_c - ack_cyc), 64'(POST_RST + 1));
    exp_q.push_back(ent(21'd0, 16'h2211, 2'b11));
    exp_q.push_back(ent(21'd1, 16'h4433, 2'b11));
    check_writes("t1_wr");
    tick(4);
    chk("t1_done_count", 64'(done_cnt), 64'd1);
    chk("t1_overflow", 64'(overflow), 64'd0);

    // T2: lone odd byte, high lane only
    downloading = 1'b1;
    tick(1);
    chk("t2_rst_low", 64'(game_rst_n), 64'd0);
    send_byte(22'd5, 8'hAB);
    downloading = 1'b0;
    wait_rise("t2_rise", rise_c);
    exp_q.push_back(ent(21'd2, 16'hAB00, 2'b10));
    check_writes("t2_wr");

    // T7: non-adjacent bytes and a byte on the falling edge of downloading
    downloading = 1'b1;
    tick(1);
    send_byte(22'd8, 8'h10);  tick(4);
    send_byte(22'd13, 8'h20); tick(4);
    send_byte(22'd20, 8'h50); tick(4);
    downloading = 1'b0;
    send_byte(22'd20, 8'h60);
    wait_rise("t7_rise", rise_c);
    exp_q.push_back(ent(21'd4,  16'h0010, 2'b01));
    exp_q.push_back(ent(21'd6,  16'h2000, 2'b10));
    exp_q.push_back(ent(21'd10, 16'h0050, 2'b01));
    exp_q.push_back(ent(21'd10, 16'h0060, 2'b01));
    check_writes("t7_wr");

    // T3: ack withheld, streaming overflows the FIFO
    ack_en = 1'b0;
    downloading = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(AW'(i), 8'(i + 1));
    tick(12);
    chk("t3_overflow", 64'(overflow), 64'd1);
    chk("t3_no_writes_yet", 64'(wr_log.size()), 64'd0);
    ack_en = 1'b1;
    downloading = 1'b0;
    wait_rise("t3_rise", rise_c);
    exp_q.push_back(ent(21'd0, 16'h0201, 2'b11));
    exp_q.push_back(ent(21'd1, 16'h0403, 2'b11));
    check_writes("t3_wr");

    // T4: game read
    rd_data = 16'hBEEF;
    game_addr = 21'h0100;
    game_req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (game_rdy) break;
    end
    chk("t4_rdy", 64'(game_rdy), 64'd1);
    chk("t4_dout", 64'(game_dout), 64'hBEEF);
    chk("t4_addr", 64'(rd_addr_seen), 64'h0100);
    game_req = 1'b0;
    tick(1);
    chk("t4_rdy_pulse", 64'(game_rdy), 64'd0);
    tick(4);
    chk("t4_rdy_count", 64'(rdy_cnt), 64'd1);
    chk("t4_bus_idle", 64'(sdram_req), 64'd0);

    // T5: download restarts mid-countdown
    done_before = done_cnt;
    downloading = 1'b1;
    tick(2);
    downloading = 1'b0;
    tick(2);
    chk("t5_mid_low", 64'(game_rst_n), 64'd0);
    downloading = 1'b1;
    tick(4);
    chk("t5_still_low", 64'(game_rst_n), 64'd0);
    chk("t5_no_done", 64'(done_cnt), 64'(done_before));
    downloading = 1'b0;
    wait_rise("t5_rise", rise_c);
    tick(4);
    chk("t5_single_done", 64'(done_cnt), 64'(done_before + 1));

`ifdef JTGNG_ROMLOAD_CHKSUM_EN
    // T6: checksum accumulate and clear on new download
    downloading = 1'b1;
    tick(1);
    send_byte(22'd0, 8'hFF);
    send_byte(22'd1, 8'hFF);
    send_byte(22'd2, 8'h02);
    tick(1);
    chk("t6_sum", 64'(chksum), 64'h0200);
    downloading = 1'b0;
    wait_rise("t6_rise", rise_c);
    chk("t6_hold", 64'(chksum), 64'h0200);
    downloading = 1'b1;
    tick(1);
    chk("t6_clear", 64'(chksum), 64'h0000);
    downloading = 1'b0;
    wait_rise("t6_rise2", rise_c);
    wr_log.delete();
`endif

    // T8: asynchronous reset while a write request is outstanding
    ack_en = 1'b0;
    downloading = 1'b1;
    send_byte(22'd0, 8'h99);
    send_byte(22'd1, 8'h88);
    tick(2);
    chk("t8_req_held", 64'(sdram_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t8_req_async_drop", 64'(sdram_req), 64'd0);
    chk("t8_overflow_clr", 64'(overflow), 64'd0);
    chk("t8_game_rst", 64'(game_rst_n), 64'd0);
    @(negedge clk);
    downloading = 1'b0;
    ack_en = 1'b1;
    rst_n = 1'b1;
    tick(4);
    chk("t8_fifo_lost", 64'(wr_log.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
